// File: rtl/expr_pkg.sv
// Shared definitions for the expression recognizer/evaluator pair:
// FSM states, token classes, ASCII constants and character decode helpers.
package expr_pkg;

    typedef enum logic [2:0] {
        ST_START,
        ST_OPEN,
        ST_DIGIT,
        ST_OP,
        ST_CLOSE,
        ST_ERR
    } state_e;

    typedef enum logic [2:0] {
        TK_DIGIT,
        TK_PLUS,
        TK_MUL,
        TK_LP,
        TK_RP,
        TK_BAD
    } tok_e;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_NINE = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_LP   = 8'h28;
    localparam logic [7:0] CH_RP   = 8'h29;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_ZERO) && (c <= CH_NINE);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == CH_PLUS) || (c == CH_MUL);
    endfunction

    // Map a raw character onto the token class the FSM reasons about.
    function automatic tok_e classify(input logic [7:0] c);
        if (is_digit(c))        return TK_DIGIT;
        else if (c == CH_PLUS)  return TK_PLUS;
        else if (c == CH_MUL)   return TK_MUL;
        else if (c == CH_LP)    return TK_LP;
        else if (c == CH_RP)    return TK_RP;
        else                    return TK_BAD;
    endfunction

endpackage

// File: rtl/expr_eval_if.sv
// Character stream in, evaluation status out. The source side is the
// master; the evaluator is the slave.
interface expr_eval_if #(
    parameter int WIDTH = 16
);
    logic [7:0]       in;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             ok;
    logic             ovf;
    logic             err;

    modport master (
        output in, in_valid,
        input  result, ok, ovf, err
    );

    modport slave (
        input  in, in_valid,
        output result, ok, ovf, err
    );
endinterface

// File: rtl/eval_stack.sv
// Small LIFO holding the saved {S,P} context of each open parenthesis.
// Implemented as a shift stack so the top entry is always slot 0.
module eval_stack #(
    parameter int DW    = 32,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] top_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [CW-1:0] count_q;

    // Shift entries down on push, up on pop.
    // NOTE: the storage array is deliberately not reset; only count_q decides
    // which entries are meaningful, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
        end else if (pop_i) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
        end
    end

    // Occupancy counter; push is ignored when full, pop when empty.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
        end else if (push_i && !full_o) begin
            count_q <= count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign top_o   = mem_q[0];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/expr_eval.sv
// Expression evaluator: checks the character stream against the digit /
// '+' / '*' / parenthesis grammar and evaluates it with '*' binding tighter
// than '+'. S holds the running sum, T the current term and P the pending
// multiplier applied to the next operand.
module expr_eval
    import expr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input logic        clk,
    input logic        clr_n,
    expr_eval_if.slave bus
);
    localparam int W2 = 2 * WIDTH;

    state_e           state_q;
    logic [WIDTH-1:0] s_q, t_q, p_q;
    logic             err_q, ovf_q;

    tok_e             tok;
    logic             accept, legal, push, pop;
    logic             stk_full, stk_empty;
    logic [W2-1:0]    stk_top;
    logic [WIDTH-1:0] pop_s, pop_p;
    logic [WIDTH-1:0] dval;
    logic [WIDTH:0]   sum_st;
    logic [W2-1:0]    prod_dig, prod_rp;

    assign tok    = classify(bus.in);
    assign accept = bus.in_valid && (state_q != ST_ERR);
    assign push   = accept && legal && (tok == TK_LP);
    assign pop    = accept && legal && (tok == TK_RP);
    assign pop_s  = stk_top[W2-1:WIDTH];
    assign pop_p  = stk_top[WIDTH-1:0];

    // Full-width arithmetic; the bits above WIDTH feed the overflow flag.
    assign dval     = WIDTH'(bus.in[3:0]);
    assign sum_st   = (WIDTH+1)'(s_q) + (WIDTH+1)'(t_q);
    assign prod_dig = W2'(p_q) * W2'(dval);
    assign prod_rp  = W2'(pop_p) * W2'(sum_st[WIDTH-1:0]);

    // Which tokens each state accepts; '(' needs stack room, ')' an open level.
    // NOTE: legal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        legal = 1'b0;
        case (state_q)
            ST_START, ST_OP: legal = (tok == TK_DIGIT) || ((tok == TK_LP) && !stk_full);
            ST_OPEN:         legal = (tok == TK_DIGIT);
            ST_DIGIT:        legal = (tok == TK_PLUS) || (tok == TK_MUL) ||
                                     ((tok == TK_RP) && !stk_empty);
            ST_CLOSE:        legal = (tok == TK_PLUS) || (tok == TK_MUL);
            default:         legal = 1'b0;
        endcase
    end

    // Grammar FSM and datapath; ERR freezes everything until reset.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of S, T and P regardless of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_START;
            s_q     <= '0;
            t_q     <= '0;
            p_q     <= WIDTH'(1);
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            if (!legal) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
            end else begin
                case (tok)
                    TK_DIGIT: begin
                        state_q <= ST_DIGIT;
                        t_q     <= prod_dig[WIDTH-1:0];
                        ovf_q   <= ovf_q | (|prod_dig[W2-1:WIDTH]);
                    end
                    TK_PLUS: begin
                        state_q <= ST_OP;
                        s_q     <= sum_st[WIDTH-1:0];
                        t_q     <= '0;
                        p_q     <= WIDTH'(1);
                        ovf_q   <= ovf_q | sum_st[WIDTH];
                    end
                    TK_MUL: begin
                        state_q <= ST_OP;
                        p_q     <= t_q;
                    end
                    TK_LP: begin
                        state_q <= ST_OPEN;
                        s_q     <= '0;
                        t_q     <= '0;
                        p_q     <= WIDTH'(1);
                    end
                    TK_RP: begin
                        state_q <= ST_CLOSE;
                        s_q     <= pop_s;
                        t_q     <= prod_rp[WIDTH-1:0];
                        p_q     <= WIDTH'(1);
                        ovf_q   <= ovf_q | sum_st[WIDTH] | (|prod_rp[W2-1:WIDTH]);
                    end
                    default: begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    eval_stack #(
        .DW    (W2),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .clr_n   (clr_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({s_q, p_q}),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign bus.result = sum_st[WIDTH-1:0];
    assign bus.ok     = ((state_q == ST_DIGIT) || (state_q == ST_CLOSE)) &&
                        stk_empty && !err_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;

endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream stage of the expression-string recognizer.
- Consumes the same 8-bit ASCII character stream, one character per accepted cycle.
- Grammar: single digits '0'-'9', '+', '*', '(' and ')'. Checks well-formedness and, in parallel, evaluates the expression with '*' binding tighter than '+'.
- Presents the running value plus an acceptance flag to the result display / comparison logic.

Parameters:
- WIDTH, 16: result and accumulator width; arithmetic is modulo 2^WIDTH.
- DEPTH, 1: maximum parenthesis nesting depth; 1 matches the recognizer grammar.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- in  in  8  ASCII character.
- in_valid  in  1  character qualifier; `in` is consumed only on an edge where in_valid=1.
- result  out  WIDTH  value of the expression consumed so far at the current nesting level (S+T).
- ok  out  1  consumed prefix is a complete, well-formed expression.
- ovf  out  1  sticky: some sum or product exceeded WIDTH bits.
- err  out  1  sticky: grammar violation detected.

Behaviour:
- Reset (clr_n=0, asynchronous): state=START, S=0, T=0, P=1, depth=0, err=0, ovf=0. Outputs become result=0, ok=0.
- All outputs are decoded from registers. The character accepted at edge k is reflected in the outputs immediately after edge k (no extra pipeline stage).
- Edges with in_valid=0 change nothing.
- Registers:
  - S: running sum.
  - T: current term.
  - P: pending multiplier, 1 when no '*' is pending.
  - stack: DEPTH entries of {S,P}.
- States: START, OPEN, DIGIT, OP, CLOSE, ERR. Any character not listed as legal for a state sends the FSM to ERR.
  - START: digit -> DIGIT; '(' -> OPEN.
  - OPEN: digit -> DIGIT.
  - DIGIT: '+' or '*' -> OP; ')' -> CLOSE.
  - OP: digit -> DIGIT; '(' -> OPEN.
  - CLOSE: '+' or '*' -> OP.
- Datapath updates:
  - digit d: T <= P*d.
  - '+': S <= S+T; T <= 0; P <= 1.
  - '*': P <= T.
  - '(': push {S,P}; S <= 0; T <= 0; P <= 1; depth+1. If depth==DEPTH on entry -> ERR.
  - ')': v = S+T; pop {S0,P0}; S <= S0; T <= P0*v; P <= 1; depth-1. If depth==0 on entry -> ERR.
- Results are truncated to WIDTH bits. Set ovf when any truncated sum or product discards nonzero bits. ovf does not affect ok.
- ERR: err=1; S, T, P, stack and depth are frozen; ERR is absorbing until clr_n is asserted.
- ok = (state==DIGIT or CLOSE) and depth==0 and err==0.
- result is always S+T (truncated). It is only meaningful while ok=1.
- Reset asserted mid-expression discards everything; the first valid character after release is parsed from START.

Decomposition:
- Shared package expr_pkg holds:
  - the state enum (START..ERR);
  - ASCII constants CH_ZERO, CH_NINE, CH_PLUS, CH_MUL, CH_LP, CH_RP;
  - an is_digit/is_op decode function, reused by the recognizer.
- Sub-module eval_stack: a DEPTH-entry LIFO of {S,P} with push, pop, full and empty, sharing the same clk/clr_n.
- The FSM and datapath stay in expr_eval.

Test Plan:
- "1+2*3", in_valid=1 every cycle -> after the '3' edge: result=7, ok=1, err=0, ovf=0. After '+' and after '*': ok=0.
- "2*(3+4)+5" -> result=19, ok=1. After "2*(3+4": ok=0. After ')': result=14, ok=1.
- "((1" with DEPTH=1 -> err=1 at the second '(' edge; ok stays 0 through a following "1)". Pulse clr_n low -> err=0, result=0; then "8" -> result=8, ok=1.
- WIDTH=8, "9*9*9" -> result=217 (729 mod 256), ovf=1, ok=1. Then clr_n low clears ovf.
- ")" as the first character -> err=1 at once. Separately, "1+" -> ok=0, result=1.
- "3*4" with in_valid low for 3 cycles between characters, carrying garbage bytes (e.g. 'x') -> no state change while low; final result=12, ok=1.
